// File: rtl/timer_keypad_ctrl_if.sv
// Keypad-side bundle for timer_keypad_ctrl: key inputs plus the encoded
// digit, load strobe, digit register, divided tick and error flag.
// The master modport is the keypad/timer side; the slave modport is the controller.
interface timer_keypad_ctrl_if #(
    parameter int NUM_KEYS   = 10,
    parameter int DIGIT_W    = 4,
    parameter int NUM_DIGITS = 4
);
    logic                                  enablen;
    logic [NUM_KEYS-1:0]                   teclado;
    logic [DIGIT_W-1:0]                    D;
    logic                                  loadn;
    logic [NUM_DIGITS*DIGIT_W-1:0]         digits;
    logic [$clog2(NUM_DIGITS+1)-1:0]       digit_count;
    logic                                  pgt_1Hz;
    logic                                  key_err;

    modport master (
        output enablen, teclado,
        input  D, loadn, digits, digit_count, pgt_1Hz, key_err
    );

    modport slave (
        input  enablen, teclado,
        output D, loadn, digits, digit_count, pgt_1Hz, key_err
    );
endinterface

// File: rtl/timer_keypad_ctrl.sv
// Keypad front end for the microwave timer: debounces a one-hot keypad,
// encodes each accepted key, pulses loadn once per press, shifts the digit
// into an MM:SS entry register and divides the clock down to pgt_1Hz.
// Optional build macro MULTIKEY_REJECT_EN: vectors with more than one key
// set are rejected with a one-cycle key_err pulse instead of being encoded.
module timer_keypad_ctrl #(
    parameter int NUM_KEYS        = 10,
    parameter int DIGIT_W         = 4,
    parameter int NUM_DIGITS      = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CLK_DIV         = 100
) (
    input  logic                clock,
    input  logic                clearn,
    timer_keypad_ctrl_if.slave  kp
);

    localparam int DBC_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int CNT_W = $clog2(NUM_DIGITS + 1);
    localparam int REG_W = NUM_DIGITS * DIGIT_W;

    generate
        if (NUM_KEYS > 2**DIGIT_W) begin : g_chk_keys
            $error("NUM_KEYS does not fit in DIGIT_W");
        end
        if (DEBOUNCE_CYCLES < 1) begin : g_chk_dbc
            $error("DEBOUNCE_CYCLES must be at least 1");
        end
        if ((CLK_DIV < 2) || (CLK_DIV % 2 != 0)) begin : g_chk_div
            $error("CLK_DIV must be even and at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, DEBOUNCE, EMIT, HOLD} state_t;

    state_t              state, state_nxt;
    logic [NUM_KEYS-1:0] cap, cap_nxt;
    logic [DBC_W-1:0]    dbc, dbc_nxt;
    logic                emit;
    logic                err_set;
    logic                multi_hit;
    logic [DIV_W-1:0]    div_cnt, div_nxt;

    // Lowest set key index wins, so a multi-key vector still encodes cleanly.
    function automatic logic [DIGIT_W-1:0] encode(input logic [NUM_KEYS-1:0] v);
        logic [DIGIT_W-1:0] code;
        code = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (v[i]) code = DIGIT_W'(i);
        end
        return code;
    endfunction

`ifdef MULTIKEY_REJECT_EN
    // Clearing the lowest set bit leaves something only if two or more were set.
    function automatic logic multi_key(input logic [NUM_KEYS-1:0] v);
        return |(v & (v - NUM_KEYS'(1)));
    endfunction

    assign multi_hit = multi_key(kp.teclado);
`else
    assign multi_hit = 1'b0;
`endif

    // FSM state, captured vector and debounce counter.
    always_ff @(posedge clock) begin
        if (!clearn) begin
            state <= IDLE;
            cap   <= '0;
            dbc   <= '0;
        end else begin
            state <= state_nxt;
            cap   <= cap_nxt;
            dbc   <= dbc_nxt;
        end
    end

    // Next-state logic; a disabled keypad drops straight back to IDLE from anywhere.
    always_comb begin
        state_nxt = state;
        cap_nxt   = cap;
        dbc_nxt   = dbc;
        emit      = 1'b0;
        err_set   = 1'b0;
        if (kp.enablen) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (kp.teclado != '0) begin
                        if (multi_hit) begin
                            err_set   = 1'b1;
                            state_nxt = HOLD;
                        end else begin
                            cap_nxt   = kp.teclado;
                            dbc_nxt   = '0;
                            state_nxt = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (multi_hit) begin
                        err_set   = 1'b1;
                        state_nxt = HOLD;
                    end else if (kp.teclado != cap) begin
                        state_nxt = IDLE;
                    end else if (dbc == DBC_W'(DEBOUNCE_CYCLES - 1)) begin
                        state_nxt = EMIT;
                    end else begin
                        dbc_nxt = dbc + 1'b1;
                    end
                end
                EMIT: begin
                    emit      = 1'b1;
                    state_nxt = HOLD;
                end
                HOLD: begin
                    if (kp.teclado == '0) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Registered key outputs: strobe, digit code and the entered-digit shift register.
    always_ff @(posedge clock) begin
        if (!clearn) begin
            kp.loadn       <= 1'b1;
            kp.D           <= '0;
            kp.digits      <= '0;
            kp.digit_count <= '0;
        end else begin
            kp.loadn <= ~emit;
            if (emit) begin
                kp.D      <= encode(cap);
                kp.digits <= (kp.digits << DIGIT_W) | REG_W'(encode(cap));
                if (kp.digit_count != CNT_W'(NUM_DIGITS)) begin
                    kp.digit_count <= kp.digit_count + 1'b1;
                end
            end
        end
    end

    // Rejection flag; err_set is constant low unless multi-key rejection is built in.
    always_ff @(posedge clock) begin
        if (!clearn) begin
            kp.key_err <= 1'b0;
        end else begin
            kp.key_err <= err_set;
        end
    end

    assign div_nxt = (div_cnt == DIV_W'(CLK_DIV - 1)) ? '0 : div_cnt + 1'b1;

    // Free-running divider; pgt_1Hz follows the upper half of the count.
    always_ff @(posedge clock) begin
        if (!clearn) begin
            div_cnt    <= '0;
            kp.pgt_1Hz <= 1'b0;
        end else begin
            div_cnt    <= div_nxt;
            kp.pgt_1Hz <= (div_nxt >= DIV_W'(CLK_DIV / 2));
        end
    end

endmodule
